// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file:
//   calc_aw     - address width for a given register count
//   wr_port_t   - write-port bundle {en, addr, data}, sized for the widest
//                 supported configuration (addr <= AW_MAX, data <= XLEN_MAX)
//   ZERO_REG    - index of the hard-wired zero register
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int AW_MAX   = 6;    // NUM_REGS tops out at 64
    localparam int XLEN_MAX = 64;   // widest data path the bundle can carry
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic                en;
        logic [AW_MAX-1:0]   addr;
        logic [XLEN_MAX-1:0] data;
    } wr_port_t;

    function automatic int calc_aw(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// -----------------------------------------------------------------------------
// register_file_mp_if
// Bundles the read, write, issue, debug and scoreboard signals of the
// register file.
//   master : the core side (drives addresses, write data, issue)
//   slave  : the register file
// -----------------------------------------------------------------------------
interface register_file_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1
) ();
    localparam int AW = calc_aw(NUM_REGS);

    logic [NUM_RD_PORTS-1:0][AW-1:0]   rd_addr_i;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0] rd_data_o;
    logic [NUM_RD_PORTS-1:0]           rd_pending_o;
    logic [NUM_WR_PORTS-1:0]           wr_en_i;
    logic [NUM_WR_PORTS-1:0][AW-1:0]   wr_addr_i;
    logic [NUM_WR_PORTS-1:0][XLEN-1:0] wr_data_i;
    logic                              issue_en_i;
    logic [AW-1:0]                     issue_rd_i;
    logic [AW-1:0]                     dbg_addr_i;
    logic [XLEN-1:0]                   dbg_data_o;
    logic [NUM_REGS-1:0]               busy_o;

    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               issue_en_i, issue_rd_i, dbg_addr_i,
        input  rd_data_o, rd_pending_o, dbg_data_o, busy_o
    );

    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               issue_en_i, issue_rd_i, dbg_addr_i,
        output rd_data_o, rd_pending_o, dbg_data_o, busy_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// One pending bit per register. An issue sets the destination's bit, a
// committing write clears it; an issue and a write to the same register in
// one cycle leave it set because the issued instruction is the newer producer.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   issue_en_i   mark issue_rd_i pending
//   issue_rd_i   destination register of the issued instruction
//   wr_en_i      write enables, one per write port
//   wr_addr_i    write addresses, one per write port
//   busy_o       registered pending bitmask
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int NUM_WR_PORTS = 1,
    parameter int ZERO_REG_EN  = 1
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          issue_en_i,
    input  logic [calc_aw(NUM_REGS)-1:0]                  issue_rd_i,
    input  logic [NUM_WR_PORTS-1:0]                       wr_en_i,
    input  logic [NUM_WR_PORTS-1:0][calc_aw(NUM_REGS)-1:0] wr_addr_i,
    output logic [NUM_REGS-1:0]                           busy_o
);
    localparam int AW = calc_aw(NUM_REGS);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            set_vec[r] = issue_en_i && (issue_rd_i == AW'(r));
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                if (wr_en_i[k] && (wr_addr_i[k] == AW'(r))) begin
                    clr_vec[r] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if ((ZERO_REG_EN != 0) && (r == ZERO_REG)) begin
                    busy_q[r] <= 1'b0;
                end else if (set_vec[r]) begin
                    busy_q[r] <= 1'b1;     // set beats clear
                end else if (clr_vec[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Multi-port register file with same-cycle write-to-read bypass, highest-index
// write priority, optional hard-wired zero register and a pending-write
// scoreboard that flags read hazards.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          register_file_mp_if.slave:
//                  rd_addr_i / rd_data_o / rd_pending_o  read ports (comb.)
//                  wr_en_i / wr_addr_i / wr_data_i       write ports
//                  issue_en_i / issue_rd_i               scoreboard set
//                  dbg_addr_i / dbg_data_o               architected read
//                  busy_o                                pending bitmask
// XLEN is limited to regfile_pkg::XLEN_MAX by the write-port bundle.
// -----------------------------------------------------------------------------
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 1,
    parameter int ZERO_REG_EN  = 1,
    parameter int BYPASS_EN    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    register_file_mp_if.slave  bus
);
    localparam int AW = calc_aw(NUM_REGS);

    wr_port_t [NUM_WR_PORTS-1:0]       wp;
    logic                              unused_wp;
    logic [NUM_REGS-1:0][XLEN-1:0]     regs_q;
    logic [NUM_REGS-1:0]               wr_hit;
    logic [NUM_REGS-1:0][XLEN-1:0]     wr_val;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0] rd_data;
    logic [NUM_RD_PORTS-1:0]           rd_hit;
    logic [NUM_RD_PORTS-1:0]           rd_pend;
    logic [XLEN-1:0]                   dbg_data;
    logic [NUM_REGS-1:0]               busy;

    function automatic logic is_zero_addr(input logic [AW-1:0] a);
        return (ZERO_REG_EN != 0) && (a == AW'(ZERO_REG));
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            wp[k].en   = bus.wr_en_i[k];
            wp[k].addr = AW_MAX'(bus.wr_addr_i[k]);
            wp[k].data = XLEN_MAX'(bus.wr_data_i[k]);
        end
    end

    // Upper bundle bits are zero padding when XLEN/AW are below the maximum.
    assign unused_wp = ^wp;

    // Per-register write select. Ports are scanned in ascending order, so the
    // highest-index enabled port targeting a register wins.
    always_comb begin
        wr_hit = '0;
        wr_val = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                if (wp[k].en && (wp[k].addr == AW_MAX'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = XLEN'(wp[k].data);
                end
            end
        end
        if (ZERO_REG_EN != 0) begin
            wr_hit[ZERO_REG] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
        end
    end

    // Read ports: stored data, overridden by the winning same-cycle write when
    // bypass is enabled. A bypass hit also resolves a pending hazard.
    always_comb begin
        rd_data = '0;
        rd_hit  = '0;
        rd_pend = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            rd_data[p] = regs_q[bus.rd_addr_i[p]];
            if (BYPASS_EN != 0) begin
                for (int k = 0; k < NUM_WR_PORTS; k++) begin
                    if (wp[k].en && (wp[k].addr == AW_MAX'(bus.rd_addr_i[p]))) begin
                        rd_hit[p]  = 1'b1;
                        rd_data[p] = XLEN'(wp[k].data);
                    end
                end
            end
            if (is_zero_addr(bus.rd_addr_i[p])) begin
                rd_data[p] = '0;
            end
            rd_pend[p] = busy[bus.rd_addr_i[p]] && !rd_hit[p];
        end
    end

    always_comb begin
        dbg_data = regs_q[bus.dbg_addr_i];
        if (is_zero_addr(bus.dbg_addr_i)) begin
            dbg_data = '0;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .NUM_WR_PORTS (NUM_WR_PORTS),
        .ZERO_REG_EN  (ZERO_REG_EN)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_en_i (bus.issue_en_i),
        .issue_rd_i (bus.issue_rd_i),
        .wr_en_i    (bus.wr_en_i),
        .wr_addr_i  (bus.wr_addr_i),
        .busy_o     (busy)
    );

    assign bus.rd_data_o    = rd_data;
    assign bus.rd_pending_o = rd_pend;
    assign bus.dbg_data_o   = dbg_data;
    assign bus.busy_o       = busy;

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the RISC-V core's decode/writeback boundary. It generalises the single-write, two-read register file with these additions:
- configurable width, depth and port counts;
- same-cycle write-to-read bypass;
- deterministic multi-write priority;
- a per-register pending-write scoreboard that flags read hazards to the stall logic.

A debug read port exposes architected state only.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NUM_REGS, 32, register count; power of two, 2..64
- NUM_RD_PORTS, 2, read ports, 1..4
- NUM_WR_PORTS, 1, write ports, 1..2
- ZERO_REG_EN, 1, when 1, register 0 reads 0, ignores writes and is never pending
- BYPASS_EN, 1, when 1, reads forward same-cycle write data
- AW (derived, not overridable), $clog2(NUM_REGS)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr_i  in  NUM_RD_PORTS x AW  read addresses
- rd_data_o  out  NUM_RD_PORTS x XLEN  read data, combinational
- rd_pending_o  out  NUM_RD_PORTS  read-hazard flag per port
- wr_en_i  in  NUM_WR_PORTS  write enables
- wr_addr_i  in  NUM_WR_PORTS x AW  write addresses
- wr_data_i  in  NUM_WR_PORTS x XLEN  write data
- issue_en_i  in  1  mark destination register pending
- issue_rd_i  in  AW  destination register of the issued instruction
- dbg_addr_i  in  AW  debug read address
- dbg_data_o  out  XLEN  debug read data, architected state
- busy_o  out  NUM_REGS  pending bitmask, registered

## Operation
- Storage: NUM_REGS x XLEN flops. A write commits at the rising edge of clk when wr_en_i[k] is set.
- Write conflict: two enabled ports with the same address in one cycle; the higher port index wins. There is no error output.
- Zero register: when ZERO_REG_EN=1, writes to address 0 are dropped and all read/debug ports return 0 for address 0, independent of bypass.
- Read (BYPASS_EN=1):
  - If any enabled write port targets the read address this cycle, rd_data_o returns that port's wr_data_i, using the same priority as a write conflict.
  - Otherwise it returns stored data.
- Read (BYPASS_EN=0): stored data only.
- Debug port: always returns stored data, never bypassed.
- Scoreboard: busy[r] is a state bit per register.
  - Set at the edge when issue_en_i=1 and issue_rd_i=r.
  - Cleared at the edge when any write to r commits.
  - Simultaneous issue and write to the same r leaves busy[r]=1, because the newer producer wins.
  - busy[0] is constant 0 when ZERO_REG_EN=1.
- Hazard flag: rd_pending_o[p] = busy[rd_addr_i[p]] AND NOT (BYPASS_EN AND a same-cycle write to that address). A write in flight resolves the hazard combinationally.
- Reset (rst_n low, asynchronous): all registers and busy bits clear to 0. Outputs then reflect zero state: rd_data_o=0, dbg_data_o=0, rd_pending_o=0, busy_o=0. Deassertion takes effect on the next rising edge; writes and issues asserted during reset are discarded.

## Timing
- Write latency: 1 edge to the stored state. With bypass, read-visible in the same cycle (0 cycles); without bypass, visible the cycle after the edge.
- Issue latency: busy_o and rd_pending_o assert the cycle after the edge that samples issue_en_i.
- Writeback clear: rd_pending_o drops in the write cycle with bypass enabled, and the cycle after the edge without it.
- All outputs except busy_o are combinational from addresses and current state. Read address inputs have no registered paths.

## Structure
- Package regfile_pkg holds:
  - the AW computation function;
  - a typedef for the write-port bundle struct {en, addr, data};
  - the localparam for the zero register index.
- Sub-module regfile_scoreboard contains the busy-bit array and its set/clear priority, and outputs busy_o. The top level instantiates it and computes rd_pending_o.
- Data array, bypass muxes and write-priority logic live in the top level.

## Test plan
- Reset and zero register: drive rst_n=0, then release. Read ports 1 and 31 -> 0x0 on rd_data_o, busy_o=0. Then write 0xFFFFFFFF to address 0 and read address 0 -> 0x0.
- Bypass: wr_en=1, addr 5, data 0xDEADBEEF, rd_addr_i[0]=5 in the same cycle -> 0xDEADBEEF before the edge, while dbg_data_o at addr 5 -> 0x0. After the edge, dbg_data_o -> 0xDEADBEEF.
- Write conflict (NUM_WR_PORTS=2): port0 writes addr 7 with 0x11111111 and port1 writes addr 7 with 0x22222222 -> stored value and bypass both read 0x22222222.
- Scoreboard lifecycle:
  - Issue to addr 3 -> next cycle busy_o[3]=1 and rd_pending_o[1]=1 with rd_addr_i[1]=3.
  - Write addr 3 with 0xCAFEBABE -> in the same cycle rd_pending_o[1]=0 and rd_data_o[1]=0xCAFEBABE.
  - After the edge, busy_o[3]=0.
- Simultaneous issue and write to addr 9 -> busy_o[9] stays 1 and the stored value is updated.
- Async reset mid-operation: with busy_o[3]=1 and x5=0xDEADBEEF, drive rst_n=0 between edges -> busy_o=0 and all reads return 0x0 immediately, without waiting for a clock edge.
